// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, PC increment and
// the default reset vector.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam int unsigned PC_INC = 4;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // True when the low two address bits select a word boundary.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect/status bundle between the core control logic (master) and the
// fetch unit (slave).
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned IMEM_ADDR_WIDTH = 8
);

  logic                       stall;
  logic                       branch_taken;
  logic [PC_WIDTH-1:0]        branch_target;
  logic                       jal;
  logic [PC_WIDTH-1:0]        jal_target;
  logic                       jalr;
  logic [PC_WIDTH-1:0]        jalr_target;
  logic                       halt_req;
  logic [PC_WIDTH-1:0]        pc;
  logic [PC_WIDTH-1:0]        pc_plus4;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
  logic                       fetch_valid;
  logic                       halted;
  logic                       misaligned;
  logic [PC_WIDTH-1:0]        misaligned_addr;

  modport master (
    output stall, branch_taken, branch_target, jal, jal_target, jalr, jalr_target, halt_req,
    input  pc, pc_plus4, imem_addr, fetch_valid, halted, misaligned, misaligned_addr
  );

  modport slave (
    input  stall, branch_taken, branch_target, jal, jal_target, jalr, jalr_target, halt_req,
    output pc, pc_plus4, imem_addr, fetch_valid, halted, misaligned, misaligned_addr
  );

endinterface

// File: rtl/next_pc_sel.sv
// Combinational redirect arbiter: JALR > JAL > branch > sequential. Flags a
// redirect whose target is not word aligned.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jal,
  input  logic [PC_WIDTH-1:0] jal_target,
  input  logic                jalr,
  input  logic [PC_WIDTH-1:0] jalr_target,
  output logic [PC_WIDTH-1:0] target,
  output logic                misaligned
);

  logic redirect;

  // Priority select of the next PC; JALR drops bit 0 of rs1+imm.
  always_comb begin
    target   = pc_plus4;
    redirect = 1'b0;
    if (jalr) begin
      target   = jalr_target & ~PC_WIDTH'(1);
      redirect = 1'b1;
    end else if (jal) begin
      target   = jal_target;
      redirect = 1'b1;
    end else if (branch_taken) begin
      target   = branch_target;
      redirect = 1'b1;
    end
    misaligned = redirect & ~word_aligned(target[1:0]);
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register and boot/run/halt control feeding inst_mem.
// Optional feature macro: FETCH_PERF_CNT_EN adds cycle_cnt/instret_cnt outputs.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned         PC_WIDTH        = 32,
  parameter int unsigned         IMEM_ADDR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.slave bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                mis_q, mis_d;
  logic [PC_WIDTH-1:0] mis_addr_q, mis_addr_d;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] sel_target;
  logic                sel_mis;
  logic                retire;

  assign pc_plus4 = pc_q + PC_WIDTH'(PC_INC);

  next_pc_sel #(
    .PC_WIDTH(PC_WIDTH)
  ) u_next_pc_sel (
    .pc_plus4     (pc_plus4),
    .branch_taken (bus.branch_taken),
    .branch_target(bus.branch_target),
    .jal          (bus.jal),
    .jal_target   (bus.jal_target),
    .jalr         (bus.jalr),
    .jalr_target  (bus.jalr_target),
    .target       (sel_target),
    .misaligned   (sel_mis)
  );

  // Next-state and PC update; halt_req outranks stall, which outranks redirects.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mis_d      = mis_q;
    mis_addr_d = mis_addr_q;
    retire     = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (!bus.stall) begin
          if (sel_mis) begin
            state_d    = ST_HALT;
            mis_d      = 1'b1;
            mis_addr_d = sel_target;
          end else begin
            pc_d   = sel_target;
            retire = 1'b1;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // Architectural state; async reset restores boot conditions even from HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.pc_plus4        = pc_plus4;
  assign bus.imem_addr       = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign bus.fetch_valid     = (state_q == ST_RUN);
  assign bus.halted          = (state_q == ST_HALT);
  assign bus.misaligned      = mis_q;
  assign bus.misaligned_addr = mis_addr_q;

`ifdef FETCH_PERF_CNT_EN
  // Free-running cycle counter and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus random redirects,
// checked against a behavioural PC model.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_WIDTH(32), .IMEM_ADDR_WIDTH(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  fetch_unit #(
    .PC_WIDTH(32),
    .IMEM_ADDR_WIDTH(8),
    .RESET_VECTOR(RV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [7:0]  ia;
    logic        fv;
    logic        hl;
    logic        mis;
    logic [31:0] maddr;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;

  // Behavioural model: phase flags, PC, trap record, counters.
  bit          m_run, m_halt, m_mis;
  logic [31:0] m_pc, m_maddr, m_cyc, m_ins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.pc    = m_pc;
    e.pc4   = m_pc + 32'd4;
    e.ia    = 8'(m_pc >> 2);
    e.fv    = m_run;
    e.hl    = m_halt;
    e.mis   = m_mis;
    e.maddr = m_maddr;
    e.cyc   = m_cyc;
    e.ins   = m_ins;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    chk({tag, " pc"}, bus.pc, e.pc);
    chk({tag, " pc_plus4"}, bus.pc_plus4, e.pc4);
    chk({tag, " imem_addr"}, 32'(bus.imem_addr), 32'(e.ia));
    chk({tag, " fetch_valid"}, 32'(bus.fetch_valid), 32'(e.fv));
    chk({tag, " halted"}, 32'(bus.halted), 32'(e.hl));
    chk({tag, " misaligned"}, 32'(bus.misaligned), 32'(e.mis));
    chk({tag, " misaligned_addr"}, bus.misaligned_addr, e.maddr);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, " cycle_cnt"}, cycle_cnt, e.cyc);
    chk({tag, " instret_cnt"}, instret_cnt, e.ins);
`endif
  endtask

  // Monitor: pop one expectation per cycle and compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      compare("mon", e);
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit hr, input bit st, input bit bt, input logic [31:0] btg,
                      input bit jl, input logic [31:0] jtg, input bit jr,
                      input logic [31:0] jrt);
    logic [31:0] t;
    bit          redir;
    bus.halt_req      = hr;
    bus.stall         = st;
    bus.branch_taken  = bt;
    bus.branch_target = btg;
    bus.jal           = jl;
    bus.jal_target    = jtg;
    bus.jalr          = jr;
    bus.jalr_target   = jrt;
    q.push_back(model_out());
    @(posedge clk);
    m_cyc++;
    if (!m_run && !m_halt) begin
      m_run = 1;
    end else if (m_run) begin
      if (hr) begin
        m_run  = 0;
        m_halt = 1;
      end else if (!st) begin
        redir = jr || jl || bt;
        if (jr) t = jrt - (jrt % 2);
        else if (jl) t = jtg;
        else if (bt) t = btg;
        else t = m_pc + 32'd4;
        if (redir && (t % 4) != 0) begin
          m_run   = 0;
          m_halt  = 1;
          m_mis   = 1;
          m_maddr = t;
        end else begin
          m_pc = t;
          m_ins++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Async reset with an immediate check, then release at posedge+1 into BOOT.
  task automatic apply_reset();
    rst_n = 1'b0;
    m_run = 0; m_halt = 0; m_mis = 0;
    m_pc = RV; m_maddr = 0; m_cyc = 0; m_ins = 0;
    #1;
    compare("reset", model_out());
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_tgt(input bit is_jalr);
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(15) != 0) v[1:0] = 2'b00;
    if (is_jalr && $urandom_range(1) == 1) v[0] = 1'b1;
    return v;
  endfunction

  task automatic rnd_step();
    step($urandom_range(63) == 0, $urandom_range(5) == 0,
         $urandom_range(7) == 0, rnd_tgt(0),
         $urandom_range(7) == 0, rnd_tgt(0),
         $urandom_range(7) == 0, rnd_tgt(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.halt_req = 0; bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jal = 0; bus.jal_target = 0; bus.jalr = 0; bus.jalr_target = 0;
    @(posedge clk);
    #1;

    // Boot then sequential fetch, stalled branch, taken branch.
    apply_reset();
    idle(3);
    step(0, 1, 1, 32'h40, 0, 0, 0, 0);
    step(0, 0, 1, 32'h40, 0, 0, 0, 0);
    // JALR beats JAL, bit 0 cleared.
    step(0, 0, 0, 0, 1, 32'h80, 1, 32'h21);
    idle(2);
    // Misaligned JAL traps; later inputs ignored.
    step(0, 0, 0, 0, 1, 32'h42, 0, 0);
    step(0, 0, 1, 32'h100, 0, 0, 0, 0);
    idle(2);

    // halt_req at pc=0x10, redirects ignored, async reset mid-halt.
    apply_reset();
    idle(5);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h200, 1, 32'h300, 0, 0);
    idle(2);
    apply_reset();
    idle(2);
    // halt_req with misaligned redirect: no trap recorded.
    step(1, 0, 0, 0, 1, 32'h42, 0, 0);
    idle(2);

    // PC wrap at top of address space, stall cycle not retired.
    apply_reset();
    idle(1);
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Random segments.
    for (int s = 0; s < 4; s++) begin
      apply_reset();
      for (int i = 0; i < 250; i++) rnd_step();
    end

    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
